// File: rtl/cnn_layer_accel_row_prefetch_buffer.sv
// Purpose : multi-bank row prefetch buffer. Stages input-map rows into a ring of
//           C_NUM_BANKS banks and streams one padded (and optionally 2x upsampled) frame.
// Latency : accepted rd_en at cycle n -> rd_data/rd_valid/row_done/frame_done at n+1.
// Backpres: wr_ready drops while the target bank still holds unconsumed data;
//           rd_avail drops while the current data row's source bank is not yet full.
// Ports   : rd_clk/rst (sync, active-high); cfg_* latched in ST_IDLE on cfg_valid;
//           wr_data/wr_valid/wr_ready row-major input; rd_en/rd_avail read request;
//           rd_data/rd_valid/row_done/frame_done registered output; busy = not idle.
// Option  : CNN_PFB_UPSAMPLE_EN enables cfg_upsample (2x nearest neighbour); when
//           undefined the upsample input is ignored and every bank serves one row.
module cnn_layer_accel_row_prefetch_buffer #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_MAX_COLS    = 512,
  parameter int C_NUM_BANKS   = 2,
  parameter int C_MAX_PAD     = 2
) (
  input  logic                            rd_clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  input  logic [$clog2(C_MAX_COLS+1)-1:0] cfg_num_cols,
  input  logic [$clog2(C_MAX_COLS+1)-1:0] cfg_num_rows,
  input  logic [$clog2(C_MAX_PAD+1)-1:0]  cfg_pad,
  input  logic                            cfg_upsample,
  input  logic [C_PIXEL_WIDTH-1:0]        wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            rd_en,
  output logic                            rd_avail,
  output logic [C_PIXEL_WIDTH-1:0]        rd_data,
  output logic                            rd_valid,
  output logic                            row_done,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int CW = $clog2(C_MAX_COLS + 1);
  localparam int PW = $clog2(C_MAX_PAD + 1);
  localparam int OW = $clog2(2 * C_MAX_COLS + 2 * C_MAX_PAD + 1);
  localparam int AW = (C_MAX_COLS > 1) ? $clog2(C_MAX_COLS) : 1;
  localparam int BW = $clog2(C_NUM_BANKS);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t st_q, st_d;

  logic [CW-1:0]            cols_q, cols_d;
  logic [CW-1:0]            rows_q, rows_d;
  logic [PW-1:0]            pad_q, pad_d;
  logic [CW-1:0]            wr_col_q, wr_col_d;
  logic [CW-1:0]            rows_wr_q, rows_wr_d;
  logic [BW-1:0]            wr_bank_q, wr_bank_d;
  logic [BW-1:0]            rd_bank_q, rd_bank_d;
  logic [C_NUM_BANKS-1:0]   full_q, full_d;
  logic [OW-1:0]            out_row_q, out_row_d;
  logic [OW-1:0]            out_col_q, out_col_d;
  logic [C_PIXEL_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     row_done_q, row_done_d;
  logic                     frame_done_q, frame_done_d;

  logic [C_PIXEL_WIDTH-1:0] mem_q [C_NUM_BANKS][C_MAX_COLS];

`ifdef CNN_PFB_UPSAMPLE_EN
  logic up_q, up_d;
`else
  logic cfg_upsample_unused;
  assign cfg_upsample_unused = cfg_upsample;
`endif

  // Geometry of the output frame and classification of the current output pixel.
  logic [OW-1:0]            pad_w, oc, orr;
  logic [AW-1:0]            src_col;
  logic                     pad_row, pad_col, last_col, last_row, rel_row;
  logic                     cfg_ok, wr_acc, rd_acc;
  logic [C_PIXEL_WIDTH-1:0] rd_word;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    if (b == BW'(C_NUM_BANKS - 1)) return '0;
    return b + BW'(1);
  endfunction

  always_comb begin
    pad_w = OW'(pad_q);
`ifdef CNN_PFB_UPSAMPLE_EN
    oc      = (OW'(cols_q) << up_q) + (pad_w << 1);
    orr     = (OW'(rows_q) << up_q) + (pad_w << 1);
    src_col = AW'((out_col_q - pad_w) >> up_q);
    // With upsampling each source row feeds two output rows; only the second
    // (odd r-pad, i.e. r and pad of differing parity) releases the bank.
    rel_row = !up_q || (out_row_q[0] ^ pad_w[0]);
`else
    oc      = OW'(cols_q) + (pad_w << 1);
    orr     = OW'(rows_q) + (pad_w << 1);
    src_col = AW'(out_col_q - pad_w);
    rel_row = 1'b1;
`endif
    pad_row  = (out_row_q < pad_w) || (out_row_q >= orr - pad_w);
    pad_col  = (out_col_q < pad_w) || (out_col_q >= oc - pad_w);
    last_col = (out_col_q == oc - OW'(1));
    last_row = (out_row_q == orr - OW'(1));
  end

  assign rd_word = mem_q[rd_bank_q][src_col];
  assign cfg_ok  = (st_q == ST_IDLE) && cfg_valid && (cfg_num_cols != '0) && (cfg_num_rows != '0);
  assign wr_acc  = wr_valid && wr_ready;
  assign rd_acc  = rd_en && rd_avail;

  // FSM: state register
  always_ff @(posedge rd_clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // FSM: next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:   if (cfg_ok) st_d = ST_ACTIVE;
      ST_ACTIVE: if (rd_acc && last_row && last_col) st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (st_q == ST_ACTIVE);
    wr_ready = busy && !full_q[wr_bank_q] && (rows_wr_q < rows_q);
    // rd_bank tracks the source bank of the current data row; pad rows need no data.
    rd_avail = busy && (pad_row || full_q[rd_bank_q]);
  end

  // Datapath next-state
  always_comb begin
    cols_d       = cols_q;
    rows_d       = rows_q;
    pad_d        = pad_q;
    wr_col_d     = wr_col_q;
    rows_wr_d    = rows_wr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef CNN_PFB_UPSAMPLE_EN
    up_d         = up_q;
`endif
    if (cfg_ok) begin
      cols_d    = cfg_num_cols;
      rows_d    = cfg_num_rows;
      pad_d     = (cfg_pad > PW'(C_MAX_PAD)) ? PW'(C_MAX_PAD) : cfg_pad;
`ifdef CNN_PFB_UPSAMPLE_EN
      up_d      = cfg_upsample;
`endif
      wr_col_d  = '0;
      rows_wr_d = '0;
      wr_bank_d = '0;
      rd_bank_d = '0;
      full_d    = '0;
      out_row_d = '0;
      out_col_d = '0;
    end else begin
      if (wr_acc) begin
        if (wr_col_q == cols_q - CW'(1)) begin
          wr_col_d          = '0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = bank_inc(wr_bank_q);
          rows_wr_d         = rows_wr_q + CW'(1);
        end else begin
          wr_col_d = wr_col_q + CW'(1);
        end
      end
      // A release never targets the bank being filled: that bank is not full.
      if (rd_acc) begin
        rd_valid_d   = 1'b1;
        rd_data_d    = (pad_row || pad_col) ? '0 : rd_word;
        row_done_d   = last_col;
        frame_done_d = last_col && last_row;
        if (last_col) begin
          out_col_d = '0;
          out_row_d = last_row ? '0 : out_row_q + OW'(1);
          if (!pad_row && rel_row) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = bank_inc(rd_bank_q);
          end
        end else begin
          out_col_d = out_col_q + OW'(1);
        end
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      cols_q       <= '0;
      rows_q       <= '0;
      pad_q        <= '0;
      wr_col_q     <= '0;
      rows_wr_q    <= '0;
      wr_bank_q    <= '0;
      rd_bank_q    <= '0;
      full_q       <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CNN_PFB_UPSAMPLE_EN
      up_q         <= 1'b0;
`endif
    end else begin
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      pad_q        <= pad_d;
      wr_col_q     <= wr_col_d;
      rows_wr_q    <= rows_wr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
`ifdef CNN_PFB_UPSAMPLE_EN
      up_q         <= up_d;
`endif
    end
  end

  // Bank storage carries no reset; validity is tracked by the full flags.
  always_ff @(posedge rd_clk) begin
    if (!rst && wr_acc) mem_q[wr_bank_q][wr_col_q[AW-1:0]] <= wr_data;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_row_prefetch_buffer.sv
// Purpose : self-checking bench for cnn_layer_accel_row_prefetch_buffer.
// Latency : reference model expects outputs one cycle after an accepted read.
// Backpres: model predicts wr_ready/rd_avail from rows written vs rows released.
module tb_cnn_layer_accel_row_prefetch_buffer;

  localparam int PXW  = 16;
  localparam int MAXC = 512;
  localparam int NB   = 2;
  localparam int MAXP = 2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(MAXP + 1);
`ifdef CNN_PFB_UPSAMPLE_EN
  localparam bit UPS = 1'b1;
`else
  localparam bit UPS = 1'b0;
`endif

  logic           rd_clk = 1'b0;
  logic           rst, cfg_valid, cfg_upsample, wr_valid, rd_en;
  logic [CW-1:0]  cfg_num_cols, cfg_num_rows;
  logic [PW-1:0]  cfg_pad;
  logic [PXW-1:0] wr_data, rd_data;
  logic           wr_ready, rd_avail, rd_valid, row_done, frame_done, busy;

  cnn_layer_accel_row_prefetch_buffer #(
    .C_PIXEL_WIDTH(PXW), .C_MAX_COLS(MAXC), .C_NUM_BANKS(NB), .C_MAX_PAD(MAXP)
  ) dut (
    .rd_clk(rd_clk), .rst(rst), .cfg_valid(cfg_valid),
    .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows),
    .cfg_pad(cfg_pad), .cfg_upsample(cfg_upsample),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
    .row_done(row_done), .frame_done(frame_done), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [PXW-1:0] px[$];
  logic [PXW-1:0] out_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // Output pixel straight from the frame definition: zero border, then
  // nearest-neighbour lookup into the source image.
  function automatic logic [PXW-1:0] exp_px(input int r, input int c, input int cols,
                                            input int pad, input int u, input int oc, input int orr);
    if (r < pad || r >= orr - pad || c < pad || c >= oc - pad) return '0;
    return px[((r - pad) / u) * cols + (c - pad) / u];
  endfunction

  task automatic run_frame(input int cols, input int rows, input int pad_cfg, input int up_cfg,
                           input int wr_pct, input int rd_pct, input bit seq);
    int pad, u, oc, orr, total, written, released, r, c, src, budget;
    bit active, exp_v, exp_rd, exp_fd, wacc, racc, avail_e, ready_e;
    logic [PXW-1:0] exp_d;
    pad   = (pad_cfg > MAXP) ? MAXP : pad_cfg;
    u     = (UPS && up_cfg != 0) ? 2 : 1;
    oc    = u * cols + 2 * pad;
    orr   = u * rows + 2 * pad;
    total = cols * rows;
    px.delete();
    out_log.delete();
    for (int i = 0; i < total; i++) px.push_back(seq ? PXW'(i + 1) : PXW'($urandom));
    cfg_num_cols = CW'(cols);
    cfg_num_rows = CW'(rows);
    cfg_pad      = PW'(pad_cfg);
    cfg_upsample = (up_cfg != 0);
    cfg_valid    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("busy_after_cfg", 32'(busy), 32'd1);
    written = 0; released = 0; r = 0; c = 0; budget = 0;
    active = 1'b1; exp_v = 1'b0; exp_rd = 1'b0; exp_fd = 1'b0; exp_d = '0;
    while (active && budget < 5000) begin
      budget++;
      src     = (r - pad) / u;
      avail_e = (r < pad || r >= orr - pad) || (written >= (src + 1) * cols);
      ready_e = (written < total) && (written / cols < released + NB);
      chk("rd_avail", 32'(rd_avail), 32'(avail_e));
      chk("wr_ready", 32'(wr_ready), 32'(ready_e));
      wr_valid = ($urandom_range(99) < wr_pct);
      wr_data  = (written < total) ? px[written] : PXW'($urandom);
      rd_en    = ($urandom_range(99) < rd_pct);
      wacc  = wr_valid && ready_e;
      racc  = rd_en && avail_e;
      exp_v = racc;
      if (racc) begin
        exp_d  = exp_px(r, c, cols, pad, u, oc, orr);
        exp_rd = (c == oc - 1);
        exp_fd = exp_rd && (r == orr - 1);
        if (c == oc - 1) begin
          if (r >= pad && r < orr - pad && ((r - pad) % u) == u - 1) released++;
          c = 0;
          r++;
          if (r == orr) active = 1'b0;
        end else begin
          c++;
        end
      end
      if (wacc) written++;
      tick();
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rd_data", 32'(rd_data), 32'(exp_d));
        chk("row_done", 32'(row_done), 32'(exp_rd));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        out_log.push_back(rd_data);
      end
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk("frame_timeout", 32'(active), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int  cnt;
    bit  rdy, seen4;
    rst = 1'b1; cfg_valid = 1'b0; cfg_upsample = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    cfg_num_cols = '0; cfg_num_rows = '0; cfg_pad = '0; wr_data = '0;
    tick();
    tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_avail", 32'(rd_avail), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Plain 4x3 frame, continuous read.
    run_frame(4, 3, 0, 0, 100, 100, 1'b1);
    chk("c1_count", 32'(out_log.size()), 32'd12);
    chk("c1_first", 32'(out_log[0]), 32'd1);
    chk("c1_last", 32'(out_log[11]), 32'd12);

    // Padded 4x3 frame -> 6x5 output.
    run_frame(4, 3, 1, 0, 100, 100, 1'b1);
    chk("c2_count", 32'(out_log.size()), 32'd30);
    chk("c2_px6", 32'(out_log[6]), 32'd0);
    chk("c2_px7", 32'(out_log[7]), 32'd1);
    chk("c2_px10", 32'(out_log[10]), 32'd4);
    chk("c2_px12", 32'(out_log[12]), 32'd0);
    chk("c2_px13", 32'(out_log[13]), 32'd5);
    chk("c2_px29", 32'(out_log[29]), 32'd0);

    // Upsample, without and with padding.
    run_frame(2, 2, 0, 1, 100, 100, 1'b1);
    chk("up_px1", 32'(out_log[1]), UPS ? 32'd1 : 32'd2);
    chk("up_last", 32'(out_log[out_log.size() - 1]), 32'd4);
    run_frame(2, 2, 1, 1, 100, 100, 1'b1);
    chk("uppad_count", 32'(out_log.size()), UPS ? 32'd36 : 32'd16);

    // Backpressure with two banks, plus read misuse before any data.
    cfg_num_cols = CW'(4); cfg_num_rows = CW'(4); cfg_pad = '0; cfg_upsample = 1'b0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("misuse_rd_valid", 32'(rd_valid), 32'd0);
    chk("misuse_rd_avail", 32'(rd_avail), 32'd0);
    rd_en = 1'b0;
    wr_valid = 1'b1;
    cnt = 0;
    seen4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_data = PXW'(cnt + 1);
      rdy = wr_ready;
      tick();
      if (rdy) cnt++;
      if (cnt == 4 && !seen4) begin
        seen4 = 1'b1;
        chk("bp_avail_after4", 32'(rd_avail), 32'd1);
      end
    end
    wr_valid = 1'b0;
    chk("bp_count", 32'(cnt), 32'd8);
    chk("bp_wr_ready_low", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick();
      chk("bp_rd_valid", 32'(rd_valid), 32'd1);
      chk("bp_rd_data", 32'(rd_data), 32'(i + 1));
      chk("bp_wr_ready", 32'(wr_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // Reset mid-frame.
    rst = 1'b1;
    tick();
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_rd_avail", 32'(rd_avail), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_row_done", 32'(row_done), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-column config is ignored.
    cfg_num_cols = '0; cfg_num_rows = CW'(3); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("cols0_busy", 32'(busy), 32'd0);
    chk("cols0_wr_ready", 32'(wr_ready), 32'd0);

    // Fresh frame after reset starts at output pixel (0,0).
    run_frame(3, 2, 0, 0, 100, 100, 1'b1);
    chk("restart_first", 32'(out_log[0]), 32'd1);

    // Randomised frames with random write/read duty cycles.
    for (int k = 0; k < 8; k++) begin
      run_frame($urandom_range(6, 1), $urandom_range(5, 1), $urandom_range(3, 0),
                $urandom_range(1, 0), $urandom_range(100, 30), $urandom_range(100, 30), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_row_prefetch_buffer.md
# cnn_layer_accel_row_prefetch_buffer

Parametrised, multi-bank successor of the layer accelerator's single-row prefetch buffer. It stages input-map rows from the fetch path into a ring of `C_NUM_BANKS` row banks and streams one output frame toward the convolution engine. The output frame applies symmetric zero padding of 0..`C_MAX_PAD` pixels and optional 2x nearest-neighbour upsampling. Fetching of later rows overlaps reading of earlier rows, and each bank is released once its last consumer row has been emitted.

## Interface
- `C_PIXEL_WIDTH`, 16, pixel width in bits
- `C_MAX_COLS`, 512, maximum input row length (bank depth)
- `C_NUM_BANKS`, 2, number of row banks (>=2)
- `C_MAX_PAD`, 2, maximum padding per side
- Derived: CW = clog2(`C_MAX_COLS`+1); PW = clog2(`C_MAX_PAD`+1); OW = clog2(2*`C_MAX_COLS`+2*`C_MAX_PAD`+1)

Ports:
- `rd_clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  latch configuration (honoured in ST_IDLE only)
- `cfg_num_cols`  in  CW  input columns
- `cfg_num_rows`  in  CW  input rows
- `cfg_pad`  in  PW  padding per side
- `cfg_upsample`  in  1  2x upsample enable
- `wr_data`  in  `C_PIXEL_WIDTH`  input pixel, row-major
- `wr_valid`  in  1  `wr_data` valid
- `wr_ready`  out  1  buffer accepts a pixel
- `rd_en`  in  1  request next output pixel
- `rd_avail`  out  1  next output pixel can be produced
- `rd_data`  out  `C_PIXEL_WIDTH`  output pixel (registered)
- `rd_valid`  out  1  `rd_data` valid
- `row_done`  out  1  pulse with the last pixel of each output row
- `frame_done`  out  1  pulse with the last pixel of the frame
- `busy`  out  1  high outside ST_IDLE

## Operation
- Configuration:
  - Config is latched on `cfg_valid` in ST_IDLE, and the block moves to ST_ACTIVE.
  - `cfg_num_cols`==0 or `cfg_num_rows`==0: config ignored, block stays in ST_IDLE.
  - `cfg_pad` > `C_MAX_PAD` saturates to `C_MAX_PAD`.
- Output geometry: u = upsample ? 2 : 1; OC = u*cols + 2*pad; OR = u*rows + 2*pad.
- Output mapping for out_row r and out_col c:
  - The pixel is zero if r<pad, r>=OR-pad, c<pad or c>=OC-pad.
  - Otherwise the source row is (r-pad)>>(u-1) and the source column is (c-pad)>>(u-1).
- Row banks:
  - Source row k lives in bank k mod `C_NUM_BANKS`. Each bank has a full flag.
  - Write: `wr_ready` = ST_ACTIVE && !full[wr_bank] && rows_written<rows. A pixel is written on `wr_valid`&&`wr_ready`.
  - The column counter wraps at cols; at wrap the bank is marked full and wr_bank advances, modulo `C_NUM_BANKS`.
- `rd_avail`:
  - High in ST_ACTIVE when the current output row is a pad row.
  - Also high when the current output row is a data row whose source bank is full.
  - `rd_en` while `rd_avail`=0 is ignored; no counters move.
- Bank release: the source bank's full flag clears on the last pixel of an output data row when u==1, or when (r-pad) is odd with u==2.
- State machine: ST_IDLE -> ST_ACTIVE on valid config. ST_ACTIVE -> ST_IDLE on the accepted read of pixel (OR-1, OC-1).
- Writes are never accepted in ST_IDLE.

## Timing
- Read latency:
  - An accepted `rd_en` at cycle n gives `rd_data`/`rd_valid` at n+1. This applies to pad and data pixels alike.
  - `row_done` and `frame_done` align with `rd_valid` of the corresponding pixel.
  - Back-to-back `rd_en` sustains 1 pixel/cycle.
- A bank marked full at cycle n gives `rd_avail` high at n+1.
- A bank released at cycle n allows `wr_ready` for that bank at n+1.
- Simultaneous write completion of one bank and release of another in the same cycle: both take effect.
- A write to bank b in the same cycle as b's release cannot occur, because `wr_ready` was low.
- Reset values: `wr_ready`=0, `rd_avail`=0, `rd_data`=0, `rd_valid`=0, `row_done`=0, `frame_done`=0, `busy`=0. All counters and full flags are 0; state is ST_IDLE.
- Reset mid-frame discards all buffered data. There are no output pulses in the cycle after reset.

## Configuration
- `CNN_PFB_UPSAMPLE_EN` defined: `cfg_upsample` is honoured as described.
- `CNN_PFB_UPSAMPLE_EN` undefined: `cfg_upsample` is ignored and u is fixed at 1. Shift and replay logic is removed. Each bank is released after its single output row.

## Test plan
- cols=4, rows=3, pad=0, up=0, input 1..12, continuous `rd_en`:
  - Output is 1..12 in order.
  - `row_done` fires on 4, 8 and 12; `frame_done` fires on 12.
  - `busy` drops the cycle after 12.
- cols=4, rows=3, pad=1:
  - OC=6, OR=5, giving 30 pixels.
  - The first 7 outputs are 0, then 1,2,3,4, then 0,0, then 5.
  - The last 7 outputs are 0.
- Upsample, cols=2, rows=2, input A,B,C,D, pad=0: output rows are AABB, AABB, CCDD, CCDD.
- Upsample with pad=1, cols=2, rows=2:
  - 6x6 frame with a zero border.
  - The interior matches the previous case.
- Backpressure: `C_NUM_BANKS`=2, cols=4, rows=4, no `rd_en`.
  - `wr_ready` drops after 8 accepted pixels.
  - `rd_avail`=1 after the first 4.
  - Reading one output row restores `wr_ready` the cycle after its last pixel.
- Misuse and reset:
  - `rd_en` while `rd_avail`=0 gives no `rd_valid` and the next pixel is unchanged.
  - `cfg_valid` with cols=0 keeps `busy`=0.
  - `rst` asserted mid-frame gives all outputs 0 next cycle. A new config then restarts from output pixel (0,0).
